// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: operation codes, ALUOp classes, state encoding and decode helpers
package alu_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_BNE    = 5'b00011,
    OP_OR     = 5'b00100,
    OP_XOR    = 5'b00101,
    OP_SLL    = 5'b00110,
    OP_SRL    = 5'b00111,
    OP_BEQ    = 5'b01000,
    OP_SRA    = 5'b01001,
    OP_SLT    = 5'b01010,
    OP_SLTU   = 5'b01011,
    OP_BLT    = 5'b01100,
    OP_BGE    = 5'b01101,
    OP_BLTU   = 5'b01110,
    OP_BGEU   = 5'b01111,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } op_t;

  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  typedef enum logic [1:0] {IDLE, OUT, WAIT} state_t;

  function automatic op_t base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  function automatic op_t branch_op(input logic [2:0] f3);
    case (f3)
      3'b001:  return OP_BNE;
      3'b100:  return OP_BLT;
      3'b101:  return OP_BGE;
      3'b110:  return OP_BLTU;
      3'b111:  return OP_BGEU;
      default: return OP_BEQ;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct3/funct7 to operation code decoder
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [4:0] operation,
  output logic       illegal,
  output logic       multi_cycle
);

  logic [4:0] op;
  logic       bad;
  logic       mc;

  // raw decode per ALUOp class; illegal encodings collapse to ADD below
  always_comb begin
    op  = OP_ADD;
    bad = 1'b0;
    mc  = 1'b0;
    case (alu_op)
      ALU_BR: begin
        op  = branch_op(funct3);
        bad = funct3[2:1] == 2'b01;
      end
      ALU_R: begin
        if (funct7 == F7_BASE) op = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) op = OP_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) op = OP_SRA;
        else if (funct7 == F7_M && ENABLE_M) begin
          op = {2'b10, funct3};
          mc = 1'b1;
        end
        else bad = 1'b1;
      end
      ALU_I: begin
        op  = (funct3 == 3'b101 && funct7 == F7_ALT) ? OP_SRA : base_op(funct3);
        bad = (funct3 == 3'b001 && funct7 != F7_BASE) ||
              (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT);
      end
      default: op = OP_ADD;
    endcase
    operation   = bad ? OP_ADD : op;
    illegal     = bad;
    multi_cycle = mc;
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control stage with handshake, M-op latency countdown and illegal counter
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       operation,
  output logic             multi_cycle,
  output logic             stall,
  output logic             op_done,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int LAT_MAX = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int LW      = $clog2(LAT_MAX + 1);
  localparam logic [LW-1:0] MUL_INIT = LW'(MUL_LAT - 1);
  localparam logic [LW-1:0] DIV_INIT = LW'(DIV_LAT - 1);

  state_t          state;
  state_t          state_n;
  logic [LW-1:0]   cnt;
  logic [4:0]      dec_op;
  logic            dec_ill;
  logic            dec_mc;
  logic            accept;
  logic            consume;

  alu_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .operation   (dec_op),
    .illegal     (dec_ill),
    .multi_cycle (dec_mc)
  );

  // handshake, status outputs and next state; flush wins over everything
  always_comb begin
    in_ready  = !reset && !flush &&
                (state == IDLE || (state == OUT && out_ready && !multi_cycle));
    out_valid = state == OUT;
    stall     = state == WAIT;
    op_done   = stall && cnt == '0 && !flush;
    accept    = in_valid && in_ready;
    consume   = out_valid && out_ready;
    state_n   = flush                 ? IDLE :
                accept                ? OUT :
                consume               ? (multi_cycle ? WAIT : IDLE) :
                (stall && cnt == '0)  ? IDLE : state;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // output register, latency countdown and saturating illegal counter
  always_ff @(posedge clk) begin
    if (reset) begin
      operation     <= '0;
      illegal       <= 1'b0;
      multi_cycle   <= 1'b0;
      cnt           <= '0;
      illegal_count <= '0;
    end else begin
      if (accept) begin
        operation   <= dec_op;
        illegal     <= dec_ill;
        multi_cycle <= dec_mc;
        if (dec_ill && !(&illegal_count)) illegal_count <= illegal_count + CNT_W'(1);
      end
      if (consume && multi_cycle) cnt <= operation[2] ? DIV_INIT : MUL_INIT;
      else if (stall && cnt != '0) cnt <= cnt - LW'(1);
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed scoreboard bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] alu_op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;

  logic       in_ready, out_valid, multi_cycle, stall, op_done, illegal;
  logic [4:0] operation;
  logic [7:0] illegal_count;
  logic       in_ready_nm, out_valid_nm, multi_cycle_nm, stall_nm, op_done_nm, illegal_nm;
  logic [4:0] operation_nm;
  logic [7:0] illegal_count_nm;

  int n_pass = 0;
  int n_total = 0;
  logic [6:0] sb[$];

  localparam logic [4:0] RT [8] = '{5'b00010, 5'b00110, 5'b01010, 5'b01011,
                                    5'b00101, 5'b00111, 5'b00100, 5'b00000};
  localparam logic [4:0] BR [8] = '{5'b01000, 5'b00011, 5'b00010, 5'b00010,
                                    5'b01100, 5'b01101, 5'b01110, 5'b01111};

  alu_ctrl_seq #(.ENABLE_M(1'b1), .MUL_LAT(3), .DIV_LAT(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
    .multi_cycle(multi_cycle), .stall(stall), .op_done(op_done),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  alu_ctrl_seq #(.ENABLE_M(1'b0), .MUL_LAT(3), .DIV_LAT(32), .CNT_W(8)) dut_nm (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nm),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .flush(flush),
    .out_valid(out_valid_nm), .out_ready(out_ready), .operation(operation_nm),
    .multi_cycle(multi_cycle_nm), .stall(stall_nm), .op_done(op_done_nm),
    .illegal(illegal_nm), .illegal_count(illegal_count_nm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {operation, illegal, multi_cycle}
  function automatic logic [6:0] model(input logic [1:0] a, input logic [2:0] f3,
                                       input logic [6:0] f7, input bit em);
    if (a == 2'd0) return {5'b00010, 2'b00};
    if (a == 2'd1) return (f3 == 3'd2 || f3 == 3'd3) ? {5'b00010, 2'b10} : {BR[f3], 2'b00};
    if (a == 2'd2) begin
      if (f7 == 7'h00) return {RT[f3], 2'b00};
      if (f7 == 7'h20 && f3 == 3'd0) return {5'b00001, 2'b00};
      if (f7 == 7'h20 && f3 == 3'd5) return {5'b01001, 2'b00};
      if (f7 == 7'h01 && em) return {2'b10, f3, 2'b01};
      return {5'b00010, 2'b10};
    end
    if (f3 == 3'd1) return (f7 == 7'h00) ? {5'b00110, 2'b00} : {5'b00010, 2'b10};
    if (f3 == 3'd5) return (f7 == 7'h00) ? {5'b00111, 2'b00} :
                           (f7 == 7'h20) ? {5'b01001, 2'b00} : {5'b00010, 2'b10};
    return {RT[f3], 2'b00};
  endfunction

  task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f3,
                       input logic [6:0] f7, input logic ordy, input logic fl,
                       output logic rdy);
    logic [6:0] e;
    in_valid = v; alu_op = a; funct3 = f3; funct7 = f7; out_ready = ordy; flush = fl;
    #1;
    rdy = in_ready;
    if (out_valid) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb[0];
        chk("operation", operation, e[6:2]);
        chk("illegal", illegal, e[1]);
        chk("multi_cycle", multi_cycle, e[0]);
      end
    end
    if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
    if (in_valid && in_ready) sb.push_back(model(a, f3, f7, 1'b1));
    @(posedge clk); #1;
  endtask

  logic [1:0] b_a  [5] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd2};
  logic [2:0] b_f3 [5] = '{3'd7, 3'd5, 3'd1, 3'd0, 3'd4};
  logic [6:0] b_f7 [5] = '{7'h00, 7'h20, 7'h55, 7'h00, 7'h00};

  initial begin
    logic rdy;
    int nst, nd, last;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_operation", operation, 0);
    chk("rst_stall", stall, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_multi_cycle", multi_cycle, 0);
    chk("rst_illegal_count", illegal_count, 0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    drive(1, 2'd2, 3'd0, 7'h20, 1, 0, rdy);
    chk("sub_out_valid", out_valid, 1);
    chk("sub_operation", operation, 5'b00001);
    chk("sub_illegal", illegal, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, b_a[i], b_f3[i], b_f7[i], 1, 0, rdy);
      chk("b2b_in_ready", rdy, 1);
      chk("b2b_out_valid", out_valid, 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'd2, 3'd6, 7'h00, 0, 0, rdy);
      chk("hold_in_ready", rdy, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_operation", operation, 5'b00101);
    end
    drive(0, 2'd0, 3'd0, 7'h00, 1, 0, rdy);
    chk("drain_out_valid", out_valid, 0);
    drive(1, 2'd2, 3'd5, 7'h01, 1, 0, rdy);
    chk("divu_operation", operation, 5'b10101);
    chk("divu_multi_cycle", multi_cycle, 1);
    chk("divu_out_stall", stall, 0);
    chk("divu_in_ready", in_ready, 0);
    chk("nm_out_valid", out_valid_nm, 1);
    chk("nm_illegal", illegal_nm, 1);
    chk("nm_multi_cycle", multi_cycle_nm, 0);
    chk("nm_operation", operation_nm, 5'b00010);
    drive(0, 2'd0, 3'd0, 7'h00, 1, 0, rdy);
    chk("nm_stall", stall_nm, 0);
    chk("nm_idle_out_valid", out_valid_nm, 0);
    nst = 0; nd = 0; last = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      nst++;
      if (op_done) begin nd++; last = nst; end
      @(posedge clk); #1;
    end
    chk("div_stall_cycles", nst, 32);
    chk("div_op_done_count", nd, 1);
    chk("div_op_done_last", last, 32);
    chk("div_stall_dropped", stall, 0);
    chk("div_in_ready_after", in_ready, 1);
    drive(1, 2'd2, 3'd0, 7'h01, 1, 0, rdy);
    chk("mul_operation", operation, 5'b10000);
    drive(0, 2'd0, 3'd0, 7'h00, 1, 0, rdy);
    chk("mul_wait1_stall", stall, 1);
    chk("mul_wait1_op_done", op_done, 0);
    @(posedge clk); #1;
    chk("mul_wait2_stall", stall, 1);
    drive(1, 2'd2, 3'd0, 7'h00, 1, 1, rdy);
    chk("flush_in_ready", rdy, 0);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_stall", stall, 0);
    chk("flush_op_done", op_done, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready_after", in_ready, 1);
    chk("flush_no_accept", sb.size(), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("flush_quiet_op_done", op_done, 0);
      chk("flush_quiet_stall", stall, 0);
    end
    for (int i = 0; i < 260; i++) begin
      drive(1, 2'd1, 3'd2, 7'h00, 1, 0, rdy);
      chk("ill_count", illegal_count, (i + 1 > 255) ? 255 : i + 1);
      chk("ill_flag", illegal, 1);
    end
    drive(0, 2'd0, 3'd0, 7'h00, 1, 0, rdy);
    chk("ill_count_sat", illegal_count, 255);
    drive(1, 2'd2, 3'd4, 7'h01, 1, 0, rdy);
    drive(0, 2'd0, 3'd0, 7'h00, 1, 0, rdy);
    repeat (5) @(posedge clk);
    #1;
    chk("midwait_stall", stall, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_operation", operation, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_op_done", op_done, 0);
    chk("mrst_illegal", illegal, 0);
    chk("mrst_multi_cycle", multi_cycle, 0);
    chk("mrst_illegal_count", illegal_count, 0);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("mrst_in_ready_after", in_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised ALU control stage that replaces the combinational ALU control decoder in the ID/EX path.
- Decodes the full RV32I ALU/branch set plus the RV32M multiply/divide ops from ALUOp, funct3 and funct7 into a 5-bit operation code, with a valid/ready handshake.
- For multi-cycle M ops it runs a latency countdown and drives a stall to the hazard unit.
- Undefined encodings are flagged and counted instead of leaving the operation code undriven.

Parameters:
- ENABLE_M, 1: 1 = decode RV32M; 0 = M encodings are illegal.
- MUL_LAT, 3: execute cycles for MUL/MULH/MULHSU/MULHU (≥1).
- DIV_LAT, 32: execute cycles for DIV/DIVU/REM/REMU (≥1).
- CNT_W, 8: width of the illegal-op counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode fields valid.
- in_ready  out  1  block accepts fields this cycle.
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- flush  in  1  pipeline flush; kills the held/in-flight op.
- out_valid  out  1  operation valid.
- out_ready  in  1  EX stage consumes operation.
- operation  out  5  ALU operation code.
- multi_cycle  out  1  current operation is an M op.
- stall  out  1  multi-cycle op executing.
- op_done  out  1  one-cycle pulse when a multi-cycle op finishes.
- illegal  out  1  current operation was undecodable.
- illegal_count  out  CNT_W  saturating count of illegal ops accepted.

Behaviour:
- Reset, synchronous and active-high: state=IDLE. All outputs 0, including the counters. Reset overrides flush and any in-flight countdown.
- States:
  - IDLE: in_ready=1. Handshake loads the output register → OUT. Latency is 1 cycle from acceptance to out_valid.
  - OUT: out_valid=1 and the outputs are held stable until out_ready.
    - in_ready = out_ready && !multi_cycle, so back-to-back single-cycle ops flow at 1 per cycle.
    - Single-cycle op consumed with no new input → IDLE.
    - Multi-cycle op consumed → WAIT, counter = LAT-1, stall=1, out_valid=0.
  - WAIT: stall=1, in_ready=0. The counter decrements each cycle. On counter==0, op_done=1 for that cycle, stall drops next cycle → IDLE.
    - Total stall cycles = LAT. With LAT=1, op_done fires in the first WAIT cycle.
- flush: in any state, next state is IDLE. out_valid, stall and op_done are 0 next cycle, with no op_done for the aborted op. An input presented in the same cycle as flush is not accepted (in_ready=0 while flush=1).
- Decode:
  - alu_op=00: ADD.
  - alu_op=01, funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Others are illegal.
  - alu_op=10, funct7=0000000, funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - alu_op=10, funct7=0100000: funct3 000 SUB, 101 SRA.
  - alu_op=10, funct7=0000001 with ENABLE_M=1, funct3 0-7: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - alu_op=10, any other funct7/funct3 combination: illegal.
  - alu_op=11: same as R-type for funct3≠001/101, with funct7 ignored and no SUB. funct3 001 needs funct7=0000000 (SLLI). funct3 101 uses funct7 0000000 SRLI or 0100000 SRAI. Otherwise illegal.
- Illegal op: operation=ADD, illegal=1, multi_cycle=0, treated as single-cycle. illegal_count increments on acceptance and saturates at all-ones.
- multi_cycle=1 only for the M codes. The countdown uses MUL_LAT when operation[2]=0 and DIV_LAT when operation[2]=1.

Decomposition:
- Package alu_ctrl_pkg:
  - Operation codes: AND 00000, SUB 00001, ADD 00010, BNE 00011, OR 00100, XOR 00101, SLL 00110, SRL 00111, BEQ 01000, SRA 01001, SLT 01010, SLTU 01011, BLT 01100, BGE 01101, BLTU 01110, BGEU 01111, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - ALUOp class constants and the state enum.
- Sub-module alu_ctrl_decode: purely combinational, giving operation, illegal and multi_cycle.
- The top level holds the FSM, output register, countdown and counter.

Test Plan:
- Reset, then alu_op=10, f7=0100000, f3=000, in_valid=1, out_ready=1 → next cycle out_valid=1, operation=00001, illegal=0.
- Five back-to-back valid ops with out_ready=1 → out_valid every cycle, in_ready never 0. Then out_ready=0 for 3 cycles → operation held, in_ready=0.
- ENABLE_M=1, DIV_LAT=32: DIVU accepted and consumed → stall=1 for exactly 32 cycles, op_done pulses once in the last, in_ready=1 the cycle after stall drops.
- MUL with MUL_LAT=3, flush asserted in the 2nd WAIT cycle → state IDLE next cycle, stall=0, no op_done.
- alu_op=01, f3=010 accepted 260 times, CNT_W=8 → operation=00010 and illegal=1 each time, illegal_count saturates at 255.
- ENABLE_M=0, alu_op=10, f7=0000001 → illegal=1, multi_cycle=0, no stall. Reset asserted mid-WAIT in an ENABLE_M=1 run → all outputs 0 next cycle.
